// File: rtl/vector_vector_alu_multi.sv
// Per-lane vector ALU with a shift-loaded firmware table selected by chain id, a small
// vector register file for operand B and result caching, and a fixed 2-cycle pipeline.
module vector_vector_alu_multi #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int VVVRF_SIZE         = 8,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic                          bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
  output logic                          valid_out,
  output logic                          eof_out,
  output logic                          bof_out
);

  localparam int CW       = $clog2(MAX_CHAINS);
  localparam int FW_BYTES = 5 * MAX_CHAINS;
  localparam int VW       = N * DATA_WIDTH;
  localparam int MSB      = DATA_WIDTH - 1;
  localparam int RF_AW    = (VVVRF_SIZE > 1) ? $clog2(VVVRF_SIZE) : 1;
  localparam logic [7:0] MY_ID = 8'(PERSONAL_CONFIG_ID);
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // ---------------- firmware table ----------------
  logic [7:0]  fw_reg [FW_BYTES];
  logic [39:0] chain_fw [MAX_CHAINS];
  logic [39:0] chain_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FW_BYTES; i++) fw_reg[i] <= '0;
    end else if (configId == MY_ID) begin
      for (int i = 0; i < FW_BYTES - 1; i++) fw_reg[i] <= fw_reg[i+1];
      fw_reg[FW_BYTES-1] <= configData;
    end
  end

  // Chain c occupies bytes 5c..5c+4: op, addr_rd, cond, cache, cache_addr (LSB first).
  generate
    for (genvar gi = 0; gi < MAX_CHAINS; gi++) begin : g_chain
      assign chain_fw[gi] = {fw_reg[5*gi+4], fw_reg[5*gi+3], fw_reg[5*gi+2],
                             fw_reg[5*gi+1], fw_reg[5*gi]};
    end
  endgenerate

  assign chain_sel = chain_fw[chainId_in];

  // ---------------- stage 1 ----------------
  logic [VW-1:0] s1_vec_reg;
  logic          s1_valid_reg, s1_eof_reg, s1_bof_reg;
  logic [CW-1:0] s1_chain_reg;
  logic [7:0]    s1_op_reg, s1_addr_rd_reg, s1_cond_reg, s1_cache_reg, s1_cache_addr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vec_reg        <= '0;
      s1_valid_reg      <= 1'b0;
      s1_eof_reg        <= 1'b0;
      s1_bof_reg        <= 1'b0;
      s1_chain_reg      <= '0;
      s1_op_reg         <= '0;
      s1_addr_rd_reg    <= '0;
      s1_cond_reg       <= '0;
      s1_cache_reg      <= '0;
      s1_cache_addr_reg <= '0;
    end else begin
      s1_vec_reg        <= vector_in;
      s1_valid_reg      <= valid_in;
      s1_eof_reg        <= eof_in;
      s1_bof_reg        <= bof_in;
      s1_chain_reg      <= chainId_in;
      s1_op_reg         <= chain_sel[7:0];
      s1_addr_rd_reg    <= chain_sel[15:8];
      s1_cond_reg       <= chain_sel[23:16];
      s1_cache_reg      <= chain_sel[31:24];
      s1_cache_addr_reg <= chain_sel[39:32];
    end
  end

  // ---------------- stage 2: operand fetch and compute ----------------
  logic [VW-1:0]    rf_reg [VVVRF_SIZE];
  logic [RF_AW-1:0] rd_idx, wr_idx;
  logic [VW-1:0]    rf_rd;
  logic [VW-1:0]    result;
  logic             cond_true;
  logic             sat;
  logic             rf_we;

  assign rd_idx = RF_AW'({24'd0, s1_addr_rd_reg} % VVVRF_SIZE);
  assign wr_idx = RF_AW'({24'd0, s1_cache_addr_reg} % VVVRF_SIZE);
  assign rf_rd  = rf_reg[rd_idx];
  assign sat    = s1_op_reg[7];

  always_comb begin
    cond_true = 1'b0;
    case (s1_cond_reg)
      8'd0:    cond_true = 1'b1;
      8'd1:    cond_true = s1_eof_reg;
      8'd2:    cond_true = ~s1_eof_reg;
      8'd3:    cond_true = s1_bof_reg;
      8'd4:    cond_true = ~s1_bof_reg;
      default: cond_true = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_a, lane_b, lane_sum, lane_dif, lane_prod, lane_res;
      logic                  add_ovf, sub_ovf;

      always_comb begin
        lane_a    = s1_vec_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        lane_b    = rf_rd[gi*DATA_WIDTH +: DATA_WIDTH];
        lane_sum  = lane_a + lane_b;
        lane_dif  = lane_a - lane_b;
        lane_prod = lane_a * lane_b;
        // Signed overflow: result sign disagrees with A while operands permit it.
        add_ovf   = (lane_a[MSB] == lane_b[MSB]) && (lane_sum[MSB] != lane_a[MSB]);
        sub_ovf   = (lane_a[MSB] != lane_b[MSB]) && (lane_dif[MSB] != lane_a[MSB]);
        lane_res  = lane_a;
        case (s1_op_reg[6:0])
          7'd1:    lane_res = (sat && add_ovf) ? (lane_a[MSB] ? SMIN : SMAX) : lane_sum;
          7'd2:    lane_res = lane_prod;
          7'd3:    lane_res = (sat && sub_ovf) ? (lane_a[MSB] ? SMIN : SMAX) : lane_dif;
          7'd4:    lane_res = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
          7'd5:    lane_res = ($signed(lane_a) < $signed(lane_b)) ? lane_a : lane_b;
          7'd6:    lane_res = lane_b;
          default: lane_res = lane_a;
        endcase
      end

      assign result[gi*DATA_WIDTH +: DATA_WIDTH] = cond_true ? lane_res : lane_a;
    end
  endgenerate

  // Only vectors whose condition fired are cached; the next vector reads the new entry.
  assign rf_we = tracing && s1_valid_reg && (s1_cache_reg != 8'd0) && cond_true;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VVVRF_SIZE; i++) rf_reg[i] <= '0;
    end else if (rf_we) begin
      rf_reg[wr_idx] <= result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vector_out  <= '0;
      chainId_out <= '0;
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      bof_out     <= 1'b0;
    end else if (tracing) begin
      vector_out  <= result;
      chainId_out <= s1_chain_reg;
      valid_out   <= s1_valid_reg;
      eof_out     <= s1_eof_reg;
      bof_out     <= s1_bof_reg;
    end else begin
      valid_out   <= 1'b0;
    end
  end

endmodule
